// File: rtl/dbg_trace_reader.sv
// dbg_trace_reader: reader side of the on-chip instruction trace buffer.
// On a start request it snapshots the writer pointer, the wrap/trigger status
// and the telemetry counters. It then streams a framed dump over valid/ready:
// a 7-word header followed by PC/INSTR pairs, oldest entry first.
// While the dump runs it holds freeze_o high so the trace writer and the
// counters stay still.
// Optional build macro: DBG_TRACE_CHECKSUM_EN appends an XOR trailer word.
`timescale 1ns/1ps

module dbg_trace_reader #(
    parameter int TRACE_DEPTH    = 64,
    parameter int TRACE_PTR_BITS = $clog2(TRACE_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      trace_triggered_i,
    input  logic                      trace_wrapped_i,
    input  logic [TRACE_PTR_BITS-1:0] trace_wr_ptr_i,
    output logic [TRACE_PTR_BITS-1:0] trace_rd_addr_o,
    input  logic [31:0]               trace_rd_pc_i,
    input  logic [31:0]               trace_rd_instr_i,
    input  logic [63:0]               tlm_mcycle_i,
    input  logic [63:0]               tlm_minstret_i,
    input  logic [63:0]               tlm_stall_i,
    output logic                      freeze_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      m_valid_o,
    output logic [31:0]               m_data_o,
    output logic                      m_last_o,
    input  logic                      m_ready_i
);

    // One extra bit so a full buffer (count == TRACE_DEPTH) is representable.
    localparam int CNT_W = TRACE_PTR_BITS + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_ISSUE,
        RD_WAIT,
        EMIT_PC,
        EMIT_INSTR,
        DONE
`ifdef DBG_TRACE_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    // State entered once the last payload word has gone out.
`ifdef DBG_TRACE_CHECKSUM_EN
    localparam state_t FRAME_END = CSUM;
`else
    localparam state_t FRAME_END = DONE;
`endif

    state_t                    state;
    state_t                    state_nxt;

    // Snapshot taken at start accept.
    logic [CNT_W-1:0]          cnt;
    logic [TRACE_PTR_BITS-1:0] base;
    logic                      trig;
    logic                      wrap;
    logic [63:0]               mcycle;
    logic [63:0]               minstret;
    logic [63:0]               stall;

    // Walk position and read holding registers.
    logic [2:0]                hdr_idx;
    logic [CNT_W-1:0]          idx;
    logic [31:0]               pc_q;
    logic [31:0]               instr_q;
    logic [31:0]               hdr_word;

`ifdef DBG_TRACE_CHECKSUM_EN
    logic [31:0]               csum;
`endif

    logic                      xfer;
    logic                      hdr_end;
    logic                      last_entry;

    assign xfer       = m_valid_o & m_ready_i;
    assign hdr_end    = (hdr_idx == 3'd6);
    assign last_entry = (idx == cnt - CNT_W'(1));

    // Oldest-first address; the sum truncates to the pointer width, which is
    // exactly the modulo-TRACE_DEPTH wrap of the circular buffer.
    assign trace_rd_addr_o = base + idx[TRACE_PTR_BITS-1:0];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:       if (start_i) state_nxt = HDR;
            HDR:        if (xfer && hdr_end)
                            state_nxt = (cnt == '0) ? FRAME_END : RD_ISSUE;
            RD_ISSUE:   state_nxt = RD_WAIT;
            RD_WAIT:    state_nxt = EMIT_PC;
            EMIT_PC:    if (xfer) state_nxt = EMIT_INSTR;
            EMIT_INSTR: if (xfer) state_nxt = last_entry ? FRAME_END : RD_ISSUE;
`ifdef DBG_TRACE_CHECKSUM_EN
            CSUM:       if (xfer) state_nxt = DONE;
`endif
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Header word selection; words 1..6 are the counters, low half first.
    always_comb begin
        hdr_word = 32'h0;
        case (hdr_idx)
            3'd0:    hdr_word = {16'hD7AC, trig, wrap, 6'b0, 8'(cnt)};
            3'd1:    hdr_word = mcycle[31:0];
            3'd2:    hdr_word = mcycle[63:32];
            3'd3:    hdr_word = minstret[31:0];
            3'd4:    hdr_word = minstret[63:32];
            3'd5:    hdr_word = stall[31:0];
            3'd6:    hdr_word = stall[63:32];
            default: hdr_word = 32'h0;
        endcase
    end

    // Outputs decoded from the state. Data comes only from registers that
    // change on a transfer, so it stays stable while the sink stalls.
    always_comb begin
        m_valid_o = 1'b0;
        m_data_o  = 32'h0;
        m_last_o  = 1'b0;
        busy_o    = 1'b1;
        freeze_o  = 1'b1;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                busy_o   = 1'b0;
                // Freeze already in the accept cycle so no write slips in
                // between the snapshot and the walk.
                freeze_o = start_i;
            end
            HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = hdr_word;
`ifndef DBG_TRACE_CHECKSUM_EN
                m_last_o  = hdr_end && (cnt == '0);
`endif
            end
            EMIT_PC: begin
                m_valid_o = 1'b1;
                m_data_o  = pc_q;
            end
            EMIT_INSTR: begin
                m_valid_o = 1'b1;
                m_data_o  = instr_q;
`ifndef DBG_TRACE_CHECKSUM_EN
                m_last_o  = last_entry;
`endif
            end
`ifdef DBG_TRACE_CHECKSUM_EN
            CSUM: begin
                m_valid_o = 1'b1;
                m_data_o  = csum;
                m_last_o  = 1'b1;
            end
`endif
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Snapshot capture, walk counters and read-data holding registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            base     <= '0;
            trig     <= 1'b0;
            wrap     <= 1'b0;
            mcycle   <= '0;
            minstret <= '0;
            stall    <= '0;
            hdr_idx  <= '0;
            idx      <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                cnt      <= trace_wrapped_i ? CNT_W'(TRACE_DEPTH)
                                            : {1'b0, trace_wr_ptr_i};
                base     <= trace_wrapped_i ? trace_wr_ptr_i : '0;
                trig     <= trace_triggered_i;
                wrap     <= trace_wrapped_i;
                mcycle   <= tlm_mcycle_i;
                minstret <= tlm_minstret_i;
                stall    <= tlm_stall_i;
                hdr_idx  <= '0;
                idx      <= '0;
            end
            if (state == HDR && xfer)
                hdr_idx <= hdr_idx + 3'd1;
            if (state == RD_WAIT) begin
                pc_q    <= trace_rd_pc_i;
                instr_q <= trace_rd_instr_i;
            end
            if (state == EMIT_INSTR && xfer)
                idx <= idx + CNT_W'(1);
        end
    end

`ifdef DBG_TRACE_CHECKSUM_EN
    // Running XOR of every word sent in the current frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            csum <= '0;
        else if (state == IDLE && start_i)
            csum <= '0;
        else if (xfer && state != CSUM)
            csum <= csum ^ m_data_o;
    end
`endif

endmodule

// File: tb/tb_dbg_trace_reader.sv
// Self-checking bench for dbg_trace_reader: a behavioural trace RAM plus a
// frame model that builds the expected word list straight from the snapshot.
`timescale 1ns/1ps

module tb_dbg_trace_reader;

    localparam int DEPTH = 64;
    localparam int PTR   = $clog2(DEPTH);

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i;
    logic            trace_triggered_i;
    logic            trace_wrapped_i;
    logic [PTR-1:0]  trace_wr_ptr_i;
    logic [PTR-1:0]  trace_rd_addr_o;
    logic [31:0]     trace_rd_pc_i;
    logic [31:0]     trace_rd_instr_i;
    logic [63:0]     tlm_mcycle_i;
    logic [63:0]     tlm_minstret_i;
    logic [63:0]     tlm_stall_i;
    logic            freeze_o;
    logic            busy_o;
    logic            done_o;
    logic            m_valid_o;
    logic [31:0]     m_data_o;
    logic            m_last_o;
    logic            m_ready_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_pc    [DEPTH];
    logic [31:0] ram_instr [DEPTH];

    dbg_trace_reader #(.TRACE_DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .trace_triggered_i (trace_triggered_i),
        .trace_wrapped_i   (trace_wrapped_i),
        .trace_wr_ptr_i    (trace_wr_ptr_i),
        .trace_rd_addr_o   (trace_rd_addr_o),
        .trace_rd_pc_i     (trace_rd_pc_i),
        .trace_rd_instr_i  (trace_rd_instr_i),
        .tlm_mcycle_i      (tlm_mcycle_i),
        .tlm_minstret_i    (tlm_minstret_i),
        .tlm_stall_i       (tlm_stall_i),
        .freeze_o          (freeze_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .m_valid_o         (m_valid_o),
        .m_data_o          (m_data_o),
        .m_last_o          (m_last_o),
        .m_ready_i         (m_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Trace RAM with a one-cycle read latency.
    always @(posedge clk_i) begin
        trace_rd_pc_i    <= ram_pc[trace_rd_addr_o];
        trace_rd_instr_i <= ram_instr[trace_rd_addr_o];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_ram(input bit random_fill);
        for (int i = 0; i < DEPTH; i++) begin
            ram_pc[i]    = random_fill ? $urandom : 32'h100 + 32'(4 * i);
            ram_instr[i] = random_fill ? $urandom : 32'h13 + 32'(i);
        end
    endtask

    // Expected frame computed from the snapshot rules.
    task automatic build_frame(input int wp, input bit wrp, input bit trg,
                               input logic [63:0] mc, input logic [63:0] mi,
                               input logic [63:0] st, output logic [31:0] q[$]);
        int cnt;
        int base;
        int a;
        logic [31:0] x;
        q = {};
        cnt  = wrp ? DEPTH : wp;
        base = wrp ? wp : 0;
        q.push_back(32'hD7AC0000 | (32'(trg) << 15) | (32'(wrp) << 14) | (32'(cnt) & 32'hFF));
        q.push_back(mc[31:0]);  q.push_back(mc[63:32]);
        q.push_back(mi[31:0]);  q.push_back(mi[63:32]);
        q.push_back(st[31:0]);  q.push_back(st[63:32]);
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % DEPTH;
            q.push_back(ram_pc[a]);
            q.push_back(ram_instr[a]);
        end
`ifdef DBG_TRACE_CHECKSUM_EN
        x = 32'h0;
        foreach (q[k]) x ^= q[k];
        q.push_back(x);
`else
        x = 32'h0;
`endif
    endtask

    // Issue a start, consume and check the whole frame.
    // poke_at >= 0 re-pulses start_i (with scrambled inputs) at that word.
    task automatic run_dump(input int wp, input bit wrp, input bit trg,
                            input logic [63:0] mc, input logic [63:0] mi,
                            input logic [63:0] st, input int rdy_pct, input int poke_at);
        logic [31:0] exp_q[$];
        int          n;
        int          cycles;
        bit          stalled;
        logic [31:0] pd;
        logic        pl;
        build_frame(wp, wrp, trg, mc, mi, st, exp_q);
        @(negedge clk_i);
        trace_wr_ptr_i    = PTR'(wp);
        trace_wrapped_i   = wrp;
        trace_triggered_i = trg;
        tlm_mcycle_i      = mc;
        tlm_minstret_i    = mi;
        tlm_stall_i       = st;
        m_ready_i         = 1'b0;
        start_i           = 1'b1;
        #1 check("freeze_on_accept", freeze_o, 1);
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0; cycles = 0; stalled = 0; pd = '0; pl = 1'b0;
        while (n < exp_q.size() && cycles < 4000) begin
            if (poke_at >= 0 && n == poke_at) begin
                start_i           = 1'b1;
                trace_wr_ptr_i    = PTR'($urandom);
                trace_wrapped_i   = ~wrp;
                trace_triggered_i = ~trg;
                tlm_mcycle_i      = {$urandom, $urandom};
                tlm_minstret_i    = {$urandom, $urandom};
                tlm_stall_i       = {$urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
            m_ready_i = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (stalled) begin
                check("stall_valid", m_valid_o, 1);
                check("stall_data", m_data_o, pd);
                check("stall_last", m_last_o, pl);
            end
            if (m_valid_o && m_ready_i) begin
                check($sformatf("word%0d", n), m_data_o, exp_q[n]);
                check($sformatf("last%0d", n), m_last_o, n == exp_q.size() - 1);
                check("freeze_during", freeze_o, 1);
                n++;
                stalled = 0;
            end else begin
                stalled = m_valid_o;
                pd      = m_data_o;
                pl      = m_last_o;
            end
            @(negedge clk_i);
            cycles++;
        end
        check("frame_words", n, exp_q.size());
        start_i   = 1'b0;
        m_ready_i = 1'b0;
        #1;
        check("done_pulse", done_o, 1);
        check("freeze_in_done", freeze_o, 1);
        check("valid_in_done", m_valid_o, 0);
        @(negedge clk_i);
        #1;
        check("done_cleared", done_o, 0);
        check("busy_after", busy_o, 0);
        check("freeze_after", freeze_o, 0);
    endtask

    // Abort a frame with reset after `at` transfers, then verify idle outputs.
    task automatic reset_mid_dump(input int at);
        int n;
        int cycles;
        @(negedge clk_i);
        trace_wr_ptr_i  = PTR'(7);
        trace_wrapped_i = 1'b1;
        m_ready_i       = 1'b1;
        start_i         = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0; cycles = 0;
        while (n < at && cycles < 1000) begin
            #1 if (m_valid_o) n++;
            @(negedge clk_i);
            cycles++;
        end
        check("reached_word", n, at);
        rst_i = 1'b1;
        #1;
        check("rst_valid", m_valid_o, 0);
        check("rst_freeze", freeze_o, 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk_i);
        #1;
        check("rst_valid_edge", m_valid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mc;
        logic [63:0] mi;
        logic [63:0] st;
        int          wp;
        bit          wrp;
        rst_i = 1'b1; start_i = 1'b0; m_ready_i = 1'b0;
        trace_triggered_i = 1'b0; trace_wrapped_i = 1'b0; trace_wr_ptr_i = '0;
        tlm_mcycle_i = '0; tlm_minstret_i = '0; tlm_stall_i = '0;
        fill_ram(1'b0);
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_m_valid", m_valid_o, 0);
        check("rst_busy0", busy_o, 0);
        check("rst_freeze0", freeze_o, 0);
        check("rst_done0", done_o, 0);
        check("rst_rd_addr", trace_rd_addr_o, 0);
        check("rst_last0", m_last_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Empty buffer: header only.
        run_dump(0, 1'b0, 1'b0, 64'd1000, 64'd400, 64'd50, 100, -1);
        // Five entries, unwrapped.
        run_dump(5, 1'b0, 1'b0, 64'd1000, 64'd400, 64'd50, 100, -1);
        // Wrapped and triggered, walk crosses the end of the buffer.
        run_dump(10, 1'b1, 1'b1, 64'h1_0000_0002, 64'h3_0000_0004, 64'h5, 100, -1);
        // Same with a 30% ready sink.
        run_dump(10, 1'b1, 1'b1, 64'h1_0000_0002, 64'h3_0000_0004, 64'h5, 30, -1);
        // start_i pulsed while busy is ignored.
        run_dump(12, 1'b0, 1'b1, 64'd77, 64'd66, 64'd55, 70, 9);
        run_dump(3, 1'b1, 1'b0, 64'd9, 64'd8, 64'd7, 100, 40);

        // Random dumps over random RAM contents.
        fill_ram(1'b1);
        for (int t = 0; t < 8; t++) begin
            wp  = $urandom_range(0, DEPTH - 1);
            wrp = 1'($urandom_range(0, 1));
            mc  = {$urandom, $urandom};
            mi  = {$urandom, $urandom};
            st  = {$urandom, $urandom};
            run_dump(wp, wrp, 1'($urandom_range(0, 1)), mc, mi, st,
                     $urandom_range(20, 100), -1);
        end

        // Reset during a frame, then a complete fresh frame.
        reset_mid_dump(20);
        run_dump(DEPTH - 1, 1'b1, 1'b1, 64'd123, 64'd456, 64'd789, 50, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_trace_reader.md
Name: dbg_trace_reader

Overview:
- Readout engine for the on-chip instruction trace buffer and telemetry counters in riscv_tcm_top; it is the reader side of the trace writer.
- On a start request it snapshots the write pointer, wrap status and the mcycle/minstret/stall counters.
- It walks the circular trace RAM oldest-first through its 1-cycle-latency read port and streams a framed dump of 32-bit words over a valid/ready interface toward the debug transport.
- While a dump is in progress it asserts freeze_o so the writer and the counters hold still.

Parameters:
- TRACE_DEPTH, 64, number of trace entries; power of 2, range 2..128.
- TRACE_PTR_BITS, $clog2(TRACE_DEPTH), width of the trace address and pointer.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle dump request.
- trace_triggered_i  in  1  trace trigger has fired.
- trace_wrapped_i  in  1  writer has wrapped at least once (buffer full).
- trace_wr_ptr_i  in  TRACE_PTR_BITS  next write slot.
- trace_rd_addr_o  out  TRACE_PTR_BITS  trace RAM read address.
- trace_rd_pc_i  in  32  read data (PC), valid 1 cycle after the address.
- trace_rd_instr_i  in  32  read data (INSTR), valid 1 cycle after the address.
- tlm_mcycle_i  in  64  cycle counter.
- tlm_minstret_i  in  64  retired-instruction counter.
- tlm_stall_i  in  64  stall-cycle counter.
- freeze_o  out  1  holds trace writes and counters during a dump.
- busy_o  out  1  dump in progress.
- done_o  out  1  one-cycle pulse after the last word transfers.
- m_valid_o  out  1  stream valid.
- m_data_o  out  32  stream data.
- m_last_o  out  1  final word of the frame.
- m_ready_i  in  1  stream ready.

Behaviour:
- Reset values: all outputs 0, trace_rd_addr_o 0, FSM in IDLE. Reset asserted mid-dump aborts the frame immediately; no partial-frame recovery.
- States: IDLE, HDR, RD_ISSUE, RD_WAIT, EMIT_PC, EMIT_INSTR, DONE.
- IDLE:
  - start_i=1 -> capture snapshot in that same cycle, set busy_o and freeze_o, go to HDR.
  - Snapshot contents: count = trace_wrapped_i ? TRACE_DEPTH : trace_wr_ptr_i; base = trace_wrapped_i ? trace_wr_ptr_i : 0; triggered, wrapped, and all three 64-bit counters.
  - start_i in any other state is ignored.
- HDR emits 7 words in order:
  - w0 = {16'hD7AC, triggered, wrapped, 6'b0, count[7:0]}.
  - w1..w6 = mcycle[31:0], mcycle[63:32], minstret[31:0], minstret[63:32], stall[31:0], stall[63:32].
  - After w6: count==0 -> m_last_o on w6, then DONE; otherwise go to RD_ISSUE with idx=0.
- RD_ISSUE: drive trace_rd_addr_o = (base+idx) mod TRACE_DEPTH, go to RD_WAIT. Address wraps naturally by pointer-width truncation.
- RD_WAIT: latch trace_rd_pc_i and trace_rd_instr_i into holding registers, go to EMIT_PC.
- EMIT_PC: present the latched PC; on transfer go to EMIT_INSTR.
- EMIT_INSTR: present the latched INSTR; on transfer, idx+1, then RD_ISSUE, or DONE if idx==count-1. m_last_o is set on the final INSTR word.
- DONE: pulse done_o for one cycle; clear busy_o and freeze_o; return to IDLE.
- Frame length: 7 + 2*count words.
- Stream handshake:
  - A transfer occurs when m_valid_o && m_ready_i.
  - m_data_o and m_last_o stay stable while m_valid_o && !m_ready_i.
  - m_valid_o never drops without a transfer.
  - m_ready_i may be held high continuously.
- Throughput: one word per cycle inside the header; 2 words per 4 cycles in the entry phase (read issue and wait overhead accepted).
- freeze_o stays high from the start-accept cycle through the DONE cycle, so the trace RAM content is stable during the walk.

Optional Feature:
- Macro DBG_TRACE_CHECKSUM_EN.
- Defined:
  - Append one trailer word: XOR of every preceding word in the frame.
  - m_last_o moves to the trailer; frame length becomes 8 + 2*count.
  - Checksum register clears at start accept.
- Undefined: no trailer; the frame ends as described in Behaviour.

Test Plan:
- wr_ptr=0, wrapped=0, triggered=0, counters=(1000,400,50), start -> 7 words: 0xD7AC0000, 1000, 0, 400, 0, 50, 0; m_last on w6; done pulse; freeze low afterwards.
- RAM model pc[i]=0x100+4i, instr[i]=0x13+i, wr_ptr=5, unwrapped -> addresses 0..4; 17 words; w0=0xD7AC0005; entries in index order; last on instr[4]=0x17.
- wrapped=1, triggered=1, wr_ptr=10 -> w0=0xD7ACC040; reads 10..63 then 0..9; 135 words; first entry PC 0x128.
- Random m_ready_i at 30% duty on the wrapped case -> stream identical to the ready-always run; data and last stable during every stall.
- start_i pulsed while busy -> no restart, frame unchanged. rst_i asserted at word 20 -> next edge m_valid_o=0, freeze_o=0, busy_o=0; a fresh start yields a full frame.
- With DBG_TRACE_CHECKSUM_EN, count=0 case -> 8th word = XOR(w0..w6); m_last only on word 8.
